fb_rect_writer: RTL and testbench

Rectangle-fill pixel writer for the 640x480, 8-bit greyscale VGA framebuffer. It accepts one fill command at a time over a valid/ready handshake and clips the command to the screen. It then emits one framebuffer write per CLOCK_50 cycle on the framebuffer's x/y/VGA_Cin/pixel_write port, in raster order. It is the drawing-side initiator upstream of the framebuffer and is used for screen clears, sprites and UI boxes.

---
 rtl/fb_rect_writer.sv | 124 ++++++++++++
 tb/tb_fb_rect_writer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fb_rect_writer.sv
// Rectangle-fill writer for the 640x480 greyscale framebuffer.
// Accepts one command at a time, clips it to the screen, then writes one pixel per clock in raster order.
module fb_rect_writer #(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [10:0] cmd_x0,
   input  logic [10:0] cmd_y0,
   input  logic [10:0] cmd_x1,
   input  logic [10:0] cmd_y1,
   input  logic [7:0]  cmd_color,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic [7:0]  VGA_Cin,
   output logic        pixel_write,
   output logic        busy,
   output logic        done
);

   localparam logic [10:0] X_LAST = 11'(H_RES - 1);
   localparam logic [10:0] Y_LAST = 11'(V_RES - 1);

   typedef enum logic [1:0] {IDLE, CLIP, DRAW, DONE} state_t;

   state_t      state_q, state_d;
   logic [10:0] xlo_q, xlo_d, xhi_q, xhi_d;
   logic [10:0] ylo_q, ylo_d, yhi_q, yhi_d;
   logic [10:0] xmax_q, xmax_d, ymax_q, ymax_d;
   logic [10:0] x_q, x_d, y_q, y_d;
   logic [7:0]  color_q, color_d, cin_q, cin_d;

   // Every register shares the asynchronous reset so an abort kills the strobe at once.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         xlo_q   <= '0;
         xhi_q   <= '0;
         ylo_q   <= '0;
         yhi_q   <= '0;
         xmax_q  <= '0;
         ymax_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
         cin_q   <= '0;
      end else begin
         state_q <= state_d;
         xlo_q   <= xlo_d;
         xhi_q   <= xhi_d;
         ylo_q   <= ylo_d;
         yhi_q   <= yhi_d;
         xmax_q  <= xmax_d;
         ymax_q  <= ymax_d;
         x_q     <= x_d;
         y_q     <= y_d;
         color_q <= color_d;
         cin_q   <= cin_d;
      end
   end

   always_comb begin
      state_d = state_q;
      xlo_d   = xlo_q;
      xhi_d   = xhi_q;
      ylo_d   = ylo_q;
      yhi_d   = yhi_q;
      xmax_d  = xmax_q;
      ymax_d  = ymax_q;
      x_d     = x_q;
      y_d     = y_q;
      color_d = color_q;
      cin_d   = cin_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               xlo_d   = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
               xhi_d   = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
               ylo_d   = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
               yhi_d   = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
               color_d = cmd_color;
               state_d = CLIP;
            end
         end
         CLIP: begin
            // A rectangle whose low corner is off-screen has nothing visible to draw.
            xmax_d = (xhi_q > X_LAST) ? X_LAST : xhi_q;
            ymax_d = (yhi_q > Y_LAST) ? Y_LAST : yhi_q;
            if ((xlo_q > X_LAST) || (ylo_q > Y_LAST)) begin
               state_d = DONE;
            end else begin
               x_d     = xlo_q;
               y_d     = ylo_q;
               cin_d   = color_q;
               state_d = DRAW;
            end
         end
         DRAW: begin
            if (x_q < xmax_q) begin
               x_d = x_q + 11'd1;
            end else if (y_q < ymax_q) begin
               x_d = xlo_q;
               y_d = y_q + 11'd1;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign pixel_write = (state_q == DRAW);
   assign x           = x_q;
   assign y           = y_q;
   assign VGA_Cin     = cin_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_fb_rect_writer;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [10:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   logic [7:0]  cmd_color = '0;
   logic [10:0] x, y;
   logic [7:0]  VGA_Cin;
   logic        pixel_write, busy, done;

   int checks = 0;
   int errors = 0;
   int writeCount = 0;
   bit monitorEn = 1'b0;
   logic [29:0] expQ[$];

   fb_rect_writer dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
      .x(x), .y(y), .VGA_Cin(VGA_Cin), .pixel_write(pixel_write), .busy(busy), .done(done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic pushPix(input int px, input int py, input logic [7:0] c);
      expQ.push_back({11'(px), 11'(py), c});
   endtask

   // Monitor: every write strobe must match the next scoreboard entry and lie on screen.
   always @(negedge CLOCK_50) begin
      if (monitorEn && pixel_write === 1'b1) begin
         writeCount++;
         checkOutput("onscreen", {30'd0, (x < 11'd640), (y < 11'd480)}, 32'd3);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_write", {2'b0, x, y, VGA_Cin}, 32'hFFFFFFFF);
         end else begin
            checkOutput("pixel", {2'b0, x, y, VGA_Cin}, {2'b0, expQ.pop_front()});
         end
      end
   end

   // Issue one command and time it: done must rise after edge k+1+W, cmd_ready after k+2+W.
   // A nonzero pokeAt raises cmd_valid with a different command while busy.
   task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                                input logic [7:0] c, input int expW, input int pokeAt);
      int edges;
      @(negedge CLOCK_50);
      #1;
      cmd_x0 = 11'(x0); cmd_y0 = 11'(y0); cmd_x1 = 11'(x1); cmd_y1 = 11'(y1);
      cmd_color = c;
      cmd_valid = 1'b1;
      checkOutput("ready_before", {31'd0, cmd_ready}, 32'd1);
      @(posedge CLOCK_50);
      #1;
      cmd_valid = 1'b0;
      checkOutput("clip_busy_notready", {30'd0, busy, cmd_ready}, 32'd2);
      checkOutput("clip_no_write", {31'd0, pixel_write}, 32'd0);
      edges = 0;
      while (edges < 40000) begin
         @(posedge CLOCK_50);
         #1;
         edges++;
         if (edges == 1) checkOutput("first_write_edge", {31'd0, pixel_write}, {31'd0, expW > 0});
         if (pokeAt != 0 && edges == pokeAt) begin
            cmd_x0 = 11'd5; cmd_y0 = 11'd5; cmd_x1 = 11'd6; cmd_y1 = 11'd6;
            cmd_color = 8'hEE;
            cmd_valid = 1'b1;
         end
         if (pokeAt != 0 && edges == pokeAt + 1) cmd_valid = 1'b0;
         if (done === 1'b1) break;
      end
      checkOutput("done_edge", edges, expW + 1);
      checkOutput("done_no_write", {31'd0, pixel_write}, 32'd0);
      @(posedge CLOCK_50);
      #1;
      checkOutput("ready_after", {29'd0, cmd_ready, done, busy}, 32'd4);
   endtask

   initial begin
      int base;
      $display("[TB] fb_rect_writer bench start");
      repeat (2) @(posedge CLOCK_50);
      #5;
      reset = 1'b1;
      #1;
      monitorEn = 1'b1;
      checkOutput("reset_ctrl", {28'd0, cmd_ready, pixel_write, busy, done}, 32'h8);
      checkOutput("reset_data", {2'b0, x, y, VGA_Cin}, 32'd0);
      cmd_valid = 1'b1;
      repeat (4) @(posedge CLOCK_50);
      #1;
      checkOutput("reset_hold", {28'd0, cmd_ready, pixel_write, busy, done}, 32'h8);
      cmd_valid = 1'b0;
      reset = 1'b0;

      // Single pixel.
      pushPix(5, 7, 8'h80);
      applyStimulus(5, 7, 5, 7, 8'h80, 1, 0);

      // Corner swap and raster order.
      pushPix(10, 20, 8'h3C); pushPix(11, 20, 8'h3C); pushPix(12, 20, 8'h3C);
      pushPix(10, 21, 8'h3C); pushPix(11, 21, 8'h3C); pushPix(12, 21, 8'h3C);
      applyStimulus(12, 21, 10, 20, 8'h3C, 6, 0);

      // Bottom-right clipping.
      pushPix(638, 478, 8'hA5); pushPix(639, 478, 8'hA5);
      pushPix(638, 479, 8'hA5); pushPix(639, 479, 8'hA5);
      applyStimulus(638, 478, 700, 600, 8'hA5, 4, 0);

      // Fully off-screen command draws nothing.
      applyStimulus(700, 0, 800, 10, 8'h11, 0, 0);
      applyStimulus(0, 480, 5, 900, 8'h22, 0, 0);

      // Wide band clear clipped on the right, with an ignored command while busy.
      for (int j = 0; j < 40; j++)
         for (int i = 0; i < 640; i++)
            pushPix(i, j, 8'h00);
      applyStimulus(2000, 39, 0, 0, 8'h00, 640 * 40, 100);
      checkOutput("queue_drained", expQ.size(), 0);

      // Abort a full clear after 1000 writes.
      for (int i = 0; i < 1000; i++) pushPix(i % 640, i / 640, 8'h7F);
      base = writeCount;
      @(negedge CLOCK_50);
      #1;
      cmd_x0 = 11'd0; cmd_y0 = 11'd0; cmd_x1 = 11'd639; cmd_y1 = 11'd479;
      cmd_color = 8'h7F;
      cmd_valid = 1'b1;
      @(posedge CLOCK_50);
      #1;
      cmd_valid = 1'b0;
      for (int n = 0; n < 1200; n++) begin
         @(negedge CLOCK_50);
         #2;
         if (writeCount - base >= 1000) break;
      end
      checkOutput("abort_count", writeCount - base, 1000);
      reset = 1'b1;
      #1;
      checkOutput("abort_ctrl", {28'd0, cmd_ready, pixel_write, busy, done}, 32'h8);
      repeat (2) @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
      checkOutput("abort_queue", expQ.size(), 0);

      pushPix(0, 0, 8'h55); pushPix(1, 0, 8'h55);
      applyStimulus(0, 0, 1, 0, 8'h55, 2, 0);
      repeat (3) @(posedge CLOCK_50);
      checkOutput("final_queue", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
